// File: rtl/wcu_pkg.sv
// Shared types and helpers for the multi-shot weapons control unit.
// Contents:
//   StateW        - width of the FSM state encoding
//   wcu_state_e   - FSM states: IDLE=0, LOCKED=1, FIRING=2, COOLDOWN=3, EMPTY=4
//   salvo_len()   - clamps a requested salvo to [1, remaining]
package wcu_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle     = 3'd0,
    StLocked   = 3'd1,
    StFiring   = 3'd2,
    StCooldown = 3'd3,
    StEmpty    = 3'd4
  } wcu_state_e;

  // A zero salvo request still releases one missile; never exceed the inventory.
  function automatic int unsigned salvo_len(input int unsigned size,
                                            input int unsigned remaining);
    int unsigned s;
    s = (size == 0) ? 1 : size;
    return (s > remaining) ? remaining : s;
  endfunction

endpackage

// File: rtl/weapons_control_unit_mc_if.sv
// Bus between the targeting/launcher side and the weapons control unit.
// Build option: WCU_ARM_INTERLOCK_EN adds the master_arm signal.
// Signals:
//   target_locked, fire_command, salvo_size, reload_req (, master_arm) - commands to the unit
//   reload_ack, launch_missile, remaining_missiles, wcu_state           - unit status
// Modports:
//   master - the commanding side (drives commands, observes status)
//   slave  - the weapons control unit
interface weapons_control_unit_mc_if #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned SALVO_W = 3
);
  import wcu_pkg::*;

  logic               target_locked;
  logic               fire_command;
  logic [SALVO_W-1:0] salvo_size;
  logic               reload_req;
`ifdef WCU_ARM_INTERLOCK_EN
  logic               master_arm;
`endif
  logic               reload_ack;
  logic               launch_missile;
  logic [CNT_W-1:0]   remaining_missiles;
  logic [StateW-1:0]  wcu_state;

  modport master (
`ifdef WCU_ARM_INTERLOCK_EN
    output master_arm,
`endif
    output target_locked,
    output fire_command,
    output salvo_size,
    output reload_req,
    input  reload_ack,
    input  launch_missile,
    input  remaining_missiles,
    input  wcu_state
  );

  modport slave (
`ifdef WCU_ARM_INTERLOCK_EN
    input  master_arm,
`endif
    input  target_locked,
    input  fire_command,
    input  salvo_size,
    input  reload_req,
    output reload_ack,
    output launch_missile,
    output remaining_missiles,
    output wcu_state
  );

endinterface

// File: rtl/wcu_cooldown_timer.sv
// Post-salvo cooldown down-counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (counter clears to 0)
//   load - reload the counter with CYCLES
//   en   - count down while the FSM sits in cooldown
//   done - high in the last cooldown cycle (counter at 1 while enabled)
module wcu_cooldown_timer #(
  parameter int unsigned CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CntW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en && (cnt_q == CntW'(1));

endmodule

// File: rtl/weapons_control_unit_mc.sv
// Multi-shot weapons control unit: magazine inventory, programmable salvos,
// post-salvo cooldown and a reload handshake.
// Build option: WCU_ARM_INTERLOCK_EN gates firing on bus.master_arm; without it the
// unit behaves as permanently armed.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - weapons_control_unit_mc_if.slave (commands in, registered status out)
module weapons_control_unit_mc
  import wcu_pkg::*;
#(
  parameter int unsigned MAX_MISSILES    = 8,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned SALVO_W         = 3,
  parameter int unsigned COOLDOWN_CYCLES = 3
) (
  input logic                       clk,
  input logic                       rst,
  weapons_control_unit_mc_if.slave  bus
);

  wcu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [SALVO_W-1:0] salvo_q, salvo_d;
  logic               launch_q, launch_d;
  logic               ack_q, ack_d;
  logic               cd_load, cd_en, cd_done;
  logic               armed;
  logic               fire_ok;

`ifdef WCU_ARM_INTERLOCK_EN
  assign armed = bus.master_arm;
`else
  assign armed = 1'b1;
`endif

  // Losing either lock or arm while firing aborts the salvo.
  assign fire_ok = bus.target_locked && armed;

  wcu_cooldown_timer #(
    .CYCLES (COOLDOWN_CYCLES)
  ) u_cooldown (
    .clk  (clk),
    .rst  (rst),
    .load (cd_load),
    .en   (cd_en),
    .done (cd_done)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rem_q    <= CNT_W'(MAX_MISSILES);
      salvo_q  <= '0;
      launch_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      salvo_q  <= salvo_d;
      launch_q <= launch_d;
      ack_q    <= ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rem_q == '0) begin
          state_d = StEmpty;
        end else if (bus.reload_req) begin
          state_d = StIdle;
        end else if (bus.target_locked) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (!bus.target_locked) begin
          state_d = StIdle;
        end else if (bus.fire_command && armed) begin
          state_d = StFiring;
        end
      end
      StFiring: begin
        if ((salvo_q == SALVO_W'(1)) || (rem_q == CNT_W'(1)) || !fire_ok) begin
          state_d = StCooldown;
        end
      end
      StCooldown: begin
        if (cd_done) begin
          if (rem_q == '0) begin
            state_d = StEmpty;
          end else if (bus.target_locked) begin
            state_d = StLocked;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StEmpty: begin
        if (bus.reload_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    rem_d   = rem_q;
    salvo_d = salvo_q;
    ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((rem_q != '0) && bus.reload_req) begin
          rem_d = CNT_W'(MAX_MISSILES);
          ack_d = 1'b1;
        end
      end
      StLocked: begin
        if (state_d == StFiring) begin
          salvo_d = SALVO_W'(salvo_len(32'(bus.salvo_size), 32'(rem_q)));
        end
      end
      StFiring: begin
        // The launch in this cycle always counts, even when aborting.
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end
        if (salvo_q != '0) begin
          salvo_d = salvo_q - SALVO_W'(1);
        end
      end
      StEmpty: begin
        if (bus.reload_req) begin
          rem_d = CNT_W'(MAX_MISSILES);
          ack_d = 1'b1;
        end
      end
      default: ;
    endcase
    launch_d = (state_d == StFiring);
    cd_load  = (state_q == StFiring) && (state_d == StCooldown);
    cd_en    = (state_q == StCooldown);
  end

  assign bus.wcu_state          = state_q;
  assign bus.remaining_missiles = rem_q;
  assign bus.launch_missile     = launch_q;
  assign bus.reload_ack         = ack_q;

endmodule

// File: tb/tb_weapons_control_unit_mc.sv
// Self-checking bench for weapons_control_unit_mc (default parameters).
// Build option: WCU_ARM_INTERLOCK_EN enables the master_arm scenario.
module tb_weapons_control_unit_mc;

  logic clk;
  logic rst;

  int total;
  int passed;

  typedef struct {
    int launches;
    int rem;
    int after_state;
  } exp_t;

  exp_t exp_q[$];

  weapons_control_unit_mc_if #(.CNT_W(4), .SALVO_W(3)) bus ();

  weapons_control_unit_mc #(
    .MAX_MISSILES    (8),
    .CNT_W           (4),
    .SALVO_W         (3),
    .COOLDOWN_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end else begin
      passed++;
    end
  endtask

  task automatic apply_reset();
    bus.target_locked = 1'b0;
    bus.fire_command  = 1'b0;
    bus.reload_req    = 1'b0;
    bus.salvo_size    = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs until the cooldown following a salvo has finished, then pops the
  // expected outcome and compares. abort_mode: 0 none, 1 drop lock, 2 drop arm.
  task automatic observe_salvo(input int abort_after, input int abort_mode,
                               output int first_launch);
    int launches;
    int cd;
    int cyc;
    bit seen_cd;
    bit done;
    exp_t e;
    launches = 0;
    cd = 0;
    cyc = 0;
    seen_cd = 1'b0;
    done = 1'b0;
    first_launch = -1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.launch_missile === 1'b1) begin
        launches++;
        if (first_launch < 0) first_launch = cyc;
        if (abort_mode != 0 && launches == abort_after) begin
`ifdef WCU_ARM_INTERLOCK_EN
          if (abort_mode == 2) bus.master_arm = 1'b0;
          else bus.target_locked = 1'b0;
`else
          bus.target_locked = 1'b0;
`endif
        end
      end
      if (bus.wcu_state === 3'd3) begin
        seen_cd = 1'b1;
        cd++;
      end else if (seen_cd) begin
        done = 1'b1;
      end
    end
    chk("salvo_timeout", int'(done), 1);
    chk("queue_nonempty", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("salvo_launches", launches, e.launches);
      chk("salvo_remaining", int'(bus.remaining_missiles), e.rem);
      chk("cooldown_cycles", cd, 3);
      chk("post_cooldown_state", int'(bus.wcu_state), e.after_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.target_locked = 1'b0;
    bus.fire_command  = 1'b0;
    bus.reload_req    = 1'b0;
    bus.salvo_size    = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_state", int'(bus.wcu_state), 0);
      chk("rst_remaining", int'(bus.remaining_missiles), 8);
      chk("rst_launch", int'(bus.launch_missile), 0);
      chk("rst_ack", int'(bus.reload_ack), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_state", int'(bus.wcu_state), 0);
      chk("idle_remaining", int'(bus.remaining_missiles), 8);
      chk("idle_launch", int'(bus.launch_missile), 0);
      chk("idle_ack", int'(bus.reload_ack), 0);
    end
  endtask

  task automatic test_salvo_and_back_to_back();
    int first;
    bus.target_locked = 1'b1;
    bus.fire_command  = 1'b1;
    bus.salvo_size    = 3'd3;
    exp_q.push_back('{launches: 3, rem: 5, after_state: 1});
    @(negedge clk);
    chk("locked_after_one_edge", int'(bus.wcu_state), 1);
    observe_salvo(0, 0, first);
    // Fire still held: one LOCKED cycle, then the next salvo starts.
    exp_q.push_back('{launches: 3, rem: 2, after_state: 1});
    observe_salvo(0, 0, first);
    chk("back_to_back_gap", first, 1);
    bus.fire_command = 1'b0;
  endtask

  task automatic test_abort();
    int first;
    apply_reset();
    bus.target_locked = 1'b1;
    bus.fire_command  = 1'b1;
    bus.salvo_size    = 3'd4;
    exp_q.push_back('{launches: 2, rem: 6, after_state: 0});
    observe_salvo(2, 1, first);
    bus.fire_command = 1'b0;
  endtask

  task automatic test_empty_reload();
    int first;
    bus.target_locked = 1'b1;
    bus.fire_command  = 1'b1;
    bus.salvo_size    = 3'd4;
    exp_q.push_back('{launches: 4, rem: 2, after_state: 1});
    observe_salvo(0, 0, first);
    exp_q.push_back('{launches: 2, rem: 0, after_state: 4});
    observe_salvo(0, 0, first);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_no_launch", int'(bus.launch_missile), 0);
      chk("empty_state", int'(bus.wcu_state), 4);
    end
    bus.reload_req = 1'b1;
    @(negedge clk);
    chk("reload_ack_high", int'(bus.reload_ack), 1);
    chk("reload_remaining", int'(bus.remaining_missiles), 8);
    chk("reload_to_idle", int'(bus.wcu_state), 0);
    bus.reload_req    = 1'b0;
    bus.target_locked = 1'b0;
    bus.fire_command  = 1'b0;
    @(negedge clk);
    chk("reload_ack_one_cycle", int'(bus.reload_ack), 0);
  endtask

  task automatic test_async_reset();
    int cyc;
    apply_reset();
    bus.target_locked = 1'b1;
    bus.fire_command  = 1'b1;
    bus.salvo_size    = 3'd7;
    cyc = 0;
    while (bus.wcu_state !== 3'd2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_firing", int'(bus.wcu_state), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_launch_drop", int'(bus.launch_missile), 0);
    chk("async_remaining", int'(bus.remaining_missiles), 8);
    chk("async_state", int'(bus.wcu_state), 0);
    @(negedge clk);
    bus.fire_command = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_resume_launch", int'(bus.launch_missile), 0);
      chk("no_resume_remaining", int'(bus.remaining_missiles), 8);
    end
    bus.target_locked = 1'b0;
  endtask

`ifdef WCU_ARM_INTERLOCK_EN
  task automatic test_arm_interlock();
    int first;
    apply_reset();
    bus.master_arm    = 1'b0;
    bus.target_locked = 1'b1;
    bus.fire_command  = 1'b1;
    bus.salvo_size    = 3'd4;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("disarmed_state", int'(bus.wcu_state), 1);
      chk("disarmed_launch", int'(bus.launch_missile), 0);
    end
    bus.master_arm = 1'b1;
    exp_q.push_back('{launches: 2, rem: 6, after_state: 1});
    observe_salvo(2, 2, first);
    bus.fire_command = 1'b0;
  endtask
`endif

  initial begin
    total  = 0;
    passed = 0;
`ifdef WCU_ARM_INTERLOCK_EN
    bus.master_arm = 1'b1;
`endif
    test_reset();
    test_salvo_and_back_to_back();
    test_abort();
    test_empty_reload();
    test_async_reset();
`ifdef WCU_ARM_INTERLOCK_EN
    test_arm_interlock();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
